// File: rtl/mem_port_if.sv
// Bus bundle for mem_port: requester, memory issue/response and retire channels.
// master = requester plus memory side; slave = the mem_port itself.
interface mem_port_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  // Request channel
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WRITE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_DATA;

  // Load issue channel
  logic                  MEM_RD_ADDR_VALID;
  logic                  MEM_RD_READY;
  logic [ADDR_WIDTH-1:0] MEM_RD_ADDR;

  // Store issue channel
  logic                  MEM_WR_VALID;
  logic                  MEM_WR_READY;
  logic [ADDR_WIDTH-1:0] MEM_WR_ADDR;
  logic [DATA_WIDTH-1:0] MEM_WR_DATA;

  // Load response channel
  logic                  MEM_RD_RESP_VALID;
  logic                  MEM_RD_RESP_READY;
  logic [ADDR_WIDTH-1:0] MEM_RD_RESP_ADDR;
  logic [DATA_WIDTH-1:0] MEM_RD_RESP_DATA;

  // Store ack channel
  logic                  MEM_WR_ACK_VALID;
  logic                  MEM_WR_ACK_READY;
  logic [DATA_WIDTH-1:0] MEM_WR_ACK_DATA;

  // Retire channel
  logic                  RESP_VALID;
  logic                  RESP_READY;
  logic                  RESP_WRITE;
  logic [ADDR_WIDTH-1:0] RESP_ADDR;
  logic [DATA_WIDTH-1:0] RESP_DATA;

  logic                  BUSY;

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_DATA,
    input  REQ_READY,
    input  MEM_RD_ADDR_VALID, MEM_RD_ADDR,
    output MEM_RD_READY,
    input  MEM_WR_VALID, MEM_WR_ADDR, MEM_WR_DATA,
    output MEM_WR_READY,
    output MEM_RD_RESP_VALID, MEM_RD_RESP_ADDR, MEM_RD_RESP_DATA,
    input  MEM_RD_RESP_READY,
    output MEM_WR_ACK_VALID, MEM_WR_ACK_DATA,
    input  MEM_WR_ACK_READY,
    input  RESP_VALID, RESP_WRITE, RESP_ADDR, RESP_DATA,
    output RESP_READY,
    input  BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_DATA,
    output REQ_READY,
    output MEM_RD_ADDR_VALID, MEM_RD_ADDR,
    input  MEM_RD_READY,
    output MEM_WR_VALID, MEM_WR_ADDR, MEM_WR_DATA,
    input  MEM_WR_READY,
    input  MEM_RD_RESP_VALID, MEM_RD_RESP_ADDR, MEM_RD_RESP_DATA,
    output MEM_RD_RESP_READY,
    input  MEM_WR_ACK_VALID, MEM_WR_ACK_DATA,
    output MEM_WR_ACK_READY,
    output RESP_VALID, RESP_WRITE, RESP_ADDR, RESP_DATA,
    input  RESP_READY,
    output BUSY
  );

endinterface

// File: rtl/mem_port.sv
// In-order memory port: accepts load/store requests, issues them through a one-entry
// issue register to separate load/store channels, and retires memory responses strictly
// in request order using a FIFO of request types.
module mem_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  mem_port_if.slave   bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t DepthC = cnt_t'(DEPTH);

  // Issue register
  logic                  iss_valid_q, iss_valid_d;
  logic                  iss_write_q, iss_write_d;
  logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
  logic [DATA_WIDTH-1:0] iss_data_q, iss_data_d;

  // Tag FIFO (1 = store, 0 = load)
  logic [DEPTH-1:0]      tag_q, tag_d;
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  cnt_t                  fifo_cnt_q, fifo_cnt_d;

  // Response register
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_write_q, resp_write_d;
  logic [ADDR_WIDTH-1:0] resp_addr_q, resp_addr_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  // Outstanding requests: accepted but not yet retired on RESP
  cnt_t                  count_q, count_d;

  logic iss_done;
  logic req_ready;
  logic req_fire;
  logic fifo_empty;
  logic head_tag;
  logic resp_free;
  logic rd_resp_ready;
  logic wr_ack_ready;
  logic rd_fire;
  logic ack_fire;
  logic resp_fire;
  logic push;
  logic pop;

  // Handshake decode
  always_comb begin
    iss_done      = iss_valid_q & (iss_write_q ? bus.MEM_WR_READY : bus.MEM_RD_READY);
    // RST_N gates ready so it drops asynchronously with reset
    req_ready     = RST_N & (count_q < DepthC) & (~iss_valid_q | iss_done);
    req_fire      = bus.REQ_VALID & req_ready;
    fifo_empty    = (fifo_cnt_q == '0);
    head_tag      = tag_q[rd_ptr_q];
    resp_free     = ~resp_valid_q | bus.RESP_READY;
    rd_resp_ready = ~fifo_empty & ~head_tag & resp_free;
    wr_ack_ready  = ~fifo_empty & head_tag & resp_free;
    rd_fire       = bus.MEM_RD_RESP_VALID & rd_resp_ready;
    ack_fire      = bus.MEM_WR_ACK_VALID & wr_ack_ready;
    resp_fire     = resp_valid_q & bus.RESP_READY;
    push          = req_fire;
    pop           = rd_fire | ack_fire;
  end

  // Issue register next state: a new request may replace one completing this cycle
  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_write_d = iss_write_q;
    iss_addr_d  = iss_addr_q;
    iss_data_d  = iss_data_q;
    if (req_fire) begin
      iss_valid_d = 1'b1;
      iss_write_d = bus.REQ_WRITE;
      iss_addr_d  = bus.REQ_ADDR;
      iss_data_d  = bus.REQ_DATA;
    end else if (iss_done) begin
      iss_valid_d = 1'b0;
    end
  end

  // Tag FIFO next state; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    tag_d      = tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      tag_d[wr_ptr_q] = bus.REQ_WRITE;
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + cnt_t'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - cnt_t'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Response register next state; stores retire with address 0
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_write_d = resp_write_q;
    resp_addr_d  = resp_addr_q;
    resp_data_d  = resp_data_q;
    if (rd_fire) begin
      resp_valid_d = 1'b1;
      resp_write_d = 1'b0;
      resp_addr_d  = bus.MEM_RD_RESP_ADDR;
      resp_data_d  = bus.MEM_RD_RESP_DATA;
    end else if (ack_fire) begin
      resp_valid_d = 1'b1;
      resp_write_d = 1'b1;
      resp_addr_d  = '0;
      resp_data_d  = bus.MEM_WR_ACK_DATA;
    end else if (resp_fire) begin
      resp_valid_d = 1'b0;
    end
  end

  // Outstanding count: accept and retire in the same cycle cancel out
  always_comb begin
    count_d = count_q;
    unique case ({req_fire, resp_fire})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      iss_valid_q  <= 1'b0;
      iss_write_q  <= 1'b0;
      iss_addr_q   <= '0;
      iss_data_q   <= '0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
      count_q      <= '0;
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_write_q  <= iss_write_d;
      iss_addr_q   <= iss_addr_d;
      iss_data_q   <= iss_data_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_addr_q  <= resp_addr_d;
      resp_data_q  <= resp_data_d;
      count_q      <= count_d;
    end
  end

  // Output drive
  always_comb begin
    bus.REQ_READY         = req_ready;
    bus.MEM_RD_ADDR_VALID = iss_valid_q & ~iss_write_q;
    bus.MEM_RD_ADDR       = iss_addr_q;
    bus.MEM_WR_VALID      = iss_valid_q & iss_write_q;
    bus.MEM_WR_ADDR       = iss_addr_q;
    bus.MEM_WR_DATA       = iss_data_q;
    bus.MEM_RD_RESP_READY = rd_resp_ready;
    bus.MEM_WR_ACK_READY  = wr_ack_ready;
    bus.RESP_VALID        = resp_valid_q;
    bus.RESP_WRITE        = resp_write_q;
    bus.RESP_ADDR         = resp_addr_q;
    bus.RESP_DATA         = resp_data_q;
    bus.BUSY              = (count_q != '0);
  end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port with a queue-based reference model checked every cycle.
module tb_mem_port;

  logic CLK = 1'b0;
  logic rst_n;

  always #5 CLK = ~CLK;

  mem_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_port #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .CLK   (CLK),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: requests awaiting issue, requests awaiting a memory response,
  // and retired responses awaiting the RESP handshake.
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  req_t pend_q[$];
  req_t order_q[$];
  req_t ret_q[$];

  always @(negedge CLK) begin
    int   outstanding;
    logic iss_fire, resp_free, head_ld, head_st;
    logic exp_req_rdy, exp_rrdy, exp_ardy;
    req_t r;
    if (!rst_n) begin
      pend_q.delete();
      order_q.delete();
      ret_q.delete();
      chk("rst_req_ready", bus.REQ_READY, 0);
      chk("rst_mem_valids", {bus.MEM_RD_ADDR_VALID, bus.MEM_WR_VALID}, 0);
      chk("rst_resp_valid", bus.RESP_VALID, 0);
      chk("rst_busy", bus.BUSY, 0);
    end else begin
      outstanding = order_q.size() + ret_q.size();
      iss_fire    = (pend_q.size() > 0) &&
                    (pend_q[0].w ? bus.MEM_WR_READY : bus.MEM_RD_READY);
      resp_free   = (ret_q.size() == 0) || bus.RESP_READY;
      head_ld     = (order_q.size() > 0) && !order_q[0].w;
      head_st     = (order_q.size() > 0) && order_q[0].w;
      exp_req_rdy = (outstanding < 4) && ((pend_q.size() == 0) || iss_fire);
      exp_rrdy    = head_ld && resp_free;
      exp_ardy    = head_st && resp_free;

      chk("m_req_ready", bus.REQ_READY, exp_req_rdy);
      chk("m_busy", bus.BUSY, outstanding != 0);
      chk("m_rd_resp_ready", bus.MEM_RD_RESP_READY, exp_rrdy);
      chk("m_wr_ack_ready", bus.MEM_WR_ACK_READY, exp_ardy);
      if (pend_q.size() > 0) begin
        chk("m_rd_valid", bus.MEM_RD_ADDR_VALID, !pend_q[0].w);
        chk("m_wr_valid", bus.MEM_WR_VALID, pend_q[0].w);
        if (pend_q[0].w) begin
          chk("m_wr_addr", bus.MEM_WR_ADDR, pend_q[0].a);
          chk("m_wr_data", bus.MEM_WR_DATA, pend_q[0].d);
        end else begin
          chk("m_rd_addr", bus.MEM_RD_ADDR, pend_q[0].a);
        end
      end else begin
        chk("m_mem_idle", {bus.MEM_RD_ADDR_VALID, bus.MEM_WR_VALID}, 0);
      end
      chk("m_resp_valid", bus.RESP_VALID, ret_q.size() > 0);
      if (ret_q.size() > 0) begin
        chk("m_resp_write", bus.RESP_WRITE, ret_q[0].w);
        chk("m_resp_addr", bus.RESP_ADDR, ret_q[0].a);
        chk("m_resp_data", bus.RESP_DATA, ret_q[0].d);
      end

      // Advance the model to reflect the coming rising edge
      if ((ret_q.size() > 0) && bus.RESP_READY) void'(ret_q.pop_front());
      if (bus.MEM_RD_RESP_VALID && exp_rrdy) begin
        void'(order_q.pop_front());
        r = '{w: 1'b0, a: bus.MEM_RD_RESP_ADDR, d: bus.MEM_RD_RESP_DATA};
        ret_q.push_back(r);
      end else if (bus.MEM_WR_ACK_VALID && exp_ardy) begin
        void'(order_q.pop_front());
        r = '{w: 1'b1, a: 32'h0, d: bus.MEM_WR_ACK_DATA};
        ret_q.push_back(r);
      end
      if (iss_fire) void'(pend_q.pop_front());
      if (bus.REQ_VALID && exp_req_rdy) begin
        r = '{w: bus.REQ_WRITE, a: bus.REQ_ADDR, d: bus.REQ_DATA};
        pend_q.push_back(r);
        order_q.push_back(r);
      end
    end
  end

  function automatic logic [31:0] lv(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic done;
    done          = 1'b0;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WRITE = w;
    bus.REQ_ADDR  = a;
    bus.REQ_DATA  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      done = bus.REQ_READY;
      tick();
    end
    bus.REQ_VALID = 1'b0;
    if (!done) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic mem_rd_resp(input logic [31:0] a, input logic [31:0] d);
    logic done;
    done                  = 1'b0;
    bus.MEM_RD_RESP_VALID = 1'b1;
    bus.MEM_RD_RESP_ADDR  = a;
    bus.MEM_RD_RESP_DATA  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      done = bus.MEM_RD_RESP_READY;
      tick();
    end
    bus.MEM_RD_RESP_VALID = 1'b0;
    if (!done) chk("rd_resp_timeout", 0, 1);
  endtask

  task automatic mem_wr_ack(input logic [31:0] d);
    logic done;
    done                 = 1'b0;
    bus.MEM_WR_ACK_VALID = 1'b1;
    bus.MEM_WR_ACK_DATA  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      done = bus.MEM_WR_ACK_READY;
      tick();
    end
    bus.MEM_WR_ACK_VALID = 1'b0;
    if (!done) chk("wr_ack_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n                 = 1'b0;
    bus.REQ_VALID         = 1'b0;
    bus.REQ_WRITE         = 1'b0;
    bus.REQ_ADDR          = '0;
    bus.REQ_DATA          = '0;
    bus.MEM_RD_READY      = 1'b1;
    bus.MEM_WR_READY      = 1'b1;
    bus.MEM_RD_RESP_VALID = 1'b0;
    bus.MEM_RD_RESP_ADDR  = '0;
    bus.MEM_RD_RESP_DATA  = '0;
    bus.MEM_WR_ACK_VALID  = 1'b0;
    bus.MEM_WR_ACK_DATA   = '0;
    bus.RESP_READY        = 1'b1;

    // Reset state
    #2;
    chk("reset_req_ready", bus.REQ_READY, 0);
    chk("reset_busy", bus.BUSY, 0);
    chk("reset_resp_valid", bus.RESP_VALID, 0);
    chk("reset_mem_valids", {bus.MEM_RD_ADDR_VALID, bus.MEM_WR_VALID}, 0);
    chk("reset_mem_readys", {bus.MEM_RD_RESP_READY, bus.MEM_WR_ACK_READY}, 0);
    chk("reset_addrs", {bus.MEM_RD_ADDR, bus.MEM_WR_ADDR}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge CLK);
    chk("release_req_ready", bus.REQ_READY, 1);
    tick();

    // Single load
    send_req(1'b0, 32'h10, 32'h0);
    @(negedge CLK);
    chk("ld_rd_valid", bus.MEM_RD_ADDR_VALID, 1);
    chk("ld_rd_addr", bus.MEM_RD_ADDR, 32'h10);
    chk("ld_wr_valid", bus.MEM_WR_VALID, 0);
    tick();
    mem_rd_resp(32'h10, 32'hAB);
    @(negedge CLK);
    chk("ld_resp_valid", bus.RESP_VALID, 1);
    chk("ld_resp_write", bus.RESP_WRITE, 0);
    chk("ld_resp_addr", bus.RESP_ADDR, 32'h10);
    chk("ld_resp_data", bus.RESP_DATA, 32'hAB);
    tick();
    @(negedge CLK);
    chk("ld_idle_busy", bus.BUSY, 0);
    tick();

    // Single store
    send_req(1'b1, 32'h20, 32'h55);
    @(negedge CLK);
    chk("st_wr_valid", bus.MEM_WR_VALID, 1);
    chk("st_wr_addr", bus.MEM_WR_ADDR, 32'h20);
    chk("st_wr_data", bus.MEM_WR_DATA, 32'h55);
    chk("st_rd_valid", bus.MEM_RD_ADDR_VALID, 0);
    tick();
    mem_wr_ack(32'h55);
    @(negedge CLK);
    chk("st_resp_write", bus.RESP_WRITE, 1);
    chk("st_resp_addr", bus.RESP_ADDR, 32'h0);
    chk("st_resp_data", bus.RESP_DATA, 32'h55);
    tick();

    // Fill to DEPTH with retire blocked
    bus.RESP_READY = 1'b0;
    for (int i = 0; i < 4; i++) send_req(1'b0, 32'h100 + 32'(i * 16), 32'h0);
    @(negedge CLK);
    chk("full_req_ready", bus.REQ_READY, 0);
    chk("full_busy", bus.BUSY, 1);
    tick();
    mem_rd_resp(32'h100, lv(32'h100));
    @(negedge CLK);
    chk("full_resp_valid", bus.RESP_VALID, 1);
    chk("full_still_blocked", bus.REQ_READY, 0);
    tick();
    bus.RESP_READY = 1'b1;
    tick();
    bus.RESP_READY = 1'b0;
    @(negedge CLK);
    chk("full_reopen", bus.REQ_READY, 1);
    tick();
    bus.RESP_READY = 1'b1;
    for (int i = 1; i < 4; i++) mem_rd_resp(32'h100 + 32'(i * 16), lv(32'h100 + 32'(i * 16)));
    repeat (2) tick();

    // Store ack offered before the older load's response
    send_req(1'b0, 32'h40, 32'h0);
    send_req(1'b1, 32'h50, 32'h77);
    bus.MEM_WR_ACK_VALID = 1'b1;
    bus.MEM_WR_ACK_DATA  = 32'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("ooo_ack_stalled", bus.MEM_WR_ACK_READY, 0);
      tick();
    end
    mem_rd_resp(32'h40, lv(32'h40));
    @(negedge CLK);
    chk("ooo_first_write", bus.RESP_WRITE, 0);
    chk("ooo_first_data", bus.RESP_DATA, lv(32'h40));
    chk("ooo_ack_ready", bus.MEM_WR_ACK_READY, 1);
    tick();
    bus.MEM_WR_ACK_VALID = 1'b0;
    @(negedge CLK);
    chk("ooo_second_valid", bus.RESP_VALID, 1);
    chk("ooo_second_write", bus.RESP_WRITE, 1);
    chk("ooo_second_data", bus.RESP_DATA, 32'h77);
    tick();
    repeat (2) tick();

    // Load issue stalled with a second request waiting
    bus.MEM_RD_READY = 1'b0;
    send_req(1'b0, 32'h60, 32'h0);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_ADDR  = 32'h70;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_rd_valid", bus.MEM_RD_ADDR_VALID, 1);
      chk("stall_rd_addr", bus.MEM_RD_ADDR, 32'h60);
      chk("stall_req_ready", bus.REQ_READY, 0);
      tick();
    end
    bus.REQ_VALID    = 1'b0;
    bus.MEM_RD_READY = 1'b1;
    send_req(1'b0, 32'h70, 32'h0);
    mem_rd_resp(32'h60, lv(32'h60));
    mem_rd_resp(32'h70, lv(32'h70));
    repeat (2) tick();

    // Reset with requests outstanding, then a fresh load
    send_req(1'b0, 32'h90, 32'h0);
    send_req(1'b0, 32'hA0, 32'h0);
    @(negedge CLK);
    chk("pre_rst_busy", bus.BUSY, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.BUSY, 0);
    chk("mid_rst_req_ready", bus.REQ_READY, 0);
    chk("mid_rst_rd_valid", bus.MEM_RD_ADDR_VALID, 0);
    chk("mid_rst_rd_addr", bus.MEM_RD_ADDR, 0);
    chk("mid_rst_resp_ready", bus.MEM_RD_RESP_READY, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge CLK);
    chk("post_rst_req_ready", bus.REQ_READY, 1);
    tick();
    send_req(1'b0, 32'h80, 32'h0);
    tick();
    mem_rd_resp(32'h80, 32'h1234);
    @(negedge CLK);
    chk("post_rst_resp_addr", bus.RESP_ADDR, 32'h80);
    chk("post_rst_resp_data", bus.RESP_DATA, 32'h1234);
    tick();
    repeat (2) tick();
    @(negedge CLK);
    chk("final_busy", bus.BUSY, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
